// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with a valid/ready request/response handshake.
// Supports byte/half/word loads and stores, error flagging and optional wait states.
module data_memory_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned MemBytes = 4 * DEPTH_WORDS;
  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned ByteW    = IdxW + 2;
  localparam int unsigned CntW     = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t            state, stateNext;
  logic [CntW-1:0]   waitCnt, waitCntNext;
  logic              capWe, capUnsigned;
  logic [1:0]        capSize;
  logic [ByteW-1:0]  capAddr;
  logic [31:0]       capWdata;
  logic              reqReadyNext, respValidNext, respErrNext;
  logic [31:0]       respRdataNext;
  logic              accept_c, reqErr_c, memWrite_c;
  logic [31:0]       loadWord_c, loadData_c, storeData_c;
  logic [7:0]        loadByte_c;
  logic [15:0]       loadHalf_c;
  logic [3:0]        byteEn_c;
  logic [IdxW-1:0]   wordIdx_c;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept_c  = req_valid && req_ready;
  assign wordIdx_c = capAddr[ByteW-1:2];

  // Alignment, size and range check on the incoming request.
  always_comb begin
    reqErr_c = 1'b0;
    case (req_size)
      2'b01:   reqErr_c = req_addr[0];
      2'b10:   reqErr_c = |req_addr[1:0];
      2'b11:   reqErr_c = 1'b1;
      default: reqErr_c = 1'b0;
    endcase
    if (req_addr >= ADDR_WIDTH'(MemBytes)) reqErr_c = 1'b1;
  end

  // Lane select and extension of the addressed word for loads.
  always_comb begin
    loadWord_c = mem[wordIdx_c];
    case (capAddr[1:0])
      2'd0:    loadByte_c = loadWord_c[7:0];
      2'd1:    loadByte_c = loadWord_c[15:8];
      2'd2:    loadByte_c = loadWord_c[23:16];
      default: loadByte_c = loadWord_c[31:24];
    endcase
    loadHalf_c = capAddr[1] ? loadWord_c[31:16] : loadWord_c[15:0];
    case (capSize)
      2'b00:   loadData_c = capUnsigned ? {24'b0, loadByte_c} : {{24{loadByte_c[7]}}, loadByte_c};
      2'b01:   loadData_c = capUnsigned ? {16'b0, loadHalf_c} : {{16{loadHalf_c[15]}}, loadHalf_c};
      default: loadData_c = loadWord_c;
    endcase
  end

  // Replicate right-aligned store data across lanes and pick the byte enables.
  always_comb begin
    storeData_c = capWdata;
    byteEn_c    = 4'b1111;
    case (capSize)
      2'b00: begin
        storeData_c = {4{capWdata[7:0]}};
        byteEn_c    = 4'b0001 << capAddr[1:0];
      end
      2'b01: begin
        storeData_c = {2{capWdata[15:0]}};
        byteEn_c    = capAddr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign memWrite_c = (state == ACCESS) && capWe;

  always_ff @(posedge clk) begin
    if (memWrite_c) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn_c[i]) mem[wordIdx_c][8*i +: 8] <= storeData_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capWe       <= 1'b0;
      capUnsigned <= 1'b0;
      capSize     <= 2'b00;
      capAddr     <= '0;
      capWdata    <= '0;
    end else if (accept_c) begin
      capWe       <= req_we;
      capUnsigned <= req_unsigned;
      capSize     <= req_size;
      capAddr     <= req_addr[ByteW-1:0];
      capWdata    <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      waitCnt    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= stateNext;
      waitCnt    <= waitCntNext;
      req_ready  <= reqReadyNext;
      resp_valid <= respValidNext;
      resp_rdata <= respRdataNext;
      resp_err   <= respErrNext;
    end
  end

  always_comb begin
    stateNext     = state;
    waitCntNext   = waitCnt;
    respValidNext = resp_valid;
    respRdataNext = resp_rdata;
    respErrNext   = resp_err;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (reqErr_c) begin
            stateNext     = RESP;
            respValidNext = 1'b1;
            respRdataNext = '0;
            respErrNext   = 1'b1;
          end else if (WAIT_CYCLES > 0) begin
            stateNext   = WAIT;
            waitCntNext = CntW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
          end else begin
            stateNext = ACCESS;
          end
        end
      end
      WAIT: begin
        if (waitCnt == '0) stateNext = ACCESS;
        else               waitCntNext = waitCnt - CntW'(1);
      end
      ACCESS: begin
        stateNext     = RESP;
        respValidNext = 1'b1;
        respRdataNext = capWe ? 32'h0 : loadData_c;
        respErrNext   = 1'b0;
      end
      RESP: begin
        if (resp_ready) begin
          stateNext     = IDLE;
          respValidNext = 1'b0;
          respRdataNext = '0;
          respErrNext   = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase
    reqReadyNext = (stateNext == IDLE);
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a zero-wait instance and a three-wait-state instance,
// checked against a queue of expected responses and a byte-level memory model.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst0, rst3;
  logic        sel;
  logic        reqValid, reqWe, reqUns, respReady;
  logic [31:0] reqAddr, reqWdata;
  logic [1:0]  reqSize;
  logic        ready0, rv0, err0, ready3, rv3, err3;
  logic [31:0] rdata0, rdata3;
  logic        reqValid0, reqValid3, respReady0, respReady3;
  logic        rReady, rValid, rErr;
  logic [31:0] rRdata;

  int nCmp = 0;
  int nBad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  logic [7:0] mdl [256];

  always #5 clk = ~clk;

  assign reqValid0  = reqValid && !sel;
  assign reqValid3  = reqValid && sel;
  assign respReady0 = respReady && !sel;
  assign respReady3 = respReady && sel;
  assign rReady = sel ? ready3 : ready0;
  assign rValid = sel ? rv3 : rv0;
  assign rErr   = sel ? err3 : err0;
  assign rRdata = sel ? rdata3 : rdata0;

  data_memory_ctrl #(.DEPTH_WORDS(1024), .ADDR_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst0), .req_valid(reqValid0), .req_ready(ready0), .req_we(reqWe),
    .req_addr(reqAddr), .req_size(reqSize), .req_unsigned(reqUns), .req_wdata(reqWdata),
    .resp_valid(rv0), .resp_ready(respReady0), .resp_rdata(rdata0), .resp_err(err0));

  data_memory_ctrl #(.DEPTH_WORDS(1024), .ADDR_WIDTH(32), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3), .req_valid(reqValid3), .req_ready(ready3), .req_we(reqWe),
    .req_addr(reqAddr), .req_size(reqSize), .req_unsigned(reqUns), .req_wdata(reqWdata),
    .resp_valid(rv3), .resp_ready(respReady3), .resp_rdata(rdata3), .resp_err(err3));

  // Issue one request, then wait for and check its response; hold stalls resp_ready.
  task automatic issue(input string name, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input logic [31:0] expRdata, input logic expErr, input int hold);
    exp_t e;
    int   cyc;
    e.rdata = expRdata;
    e.err   = expErr;
    e.lat   = expErr ? 1 : (sel ? 5 : 2);
    e.name  = name;
    nCmp++;
    if (rReady !== 1'b1) begin
      nBad++;
      $display("FAIL %s ready_before: got %b want 1", name, rReady);
    end
    sb.push_back(e);
    reqValid = 1'b1; reqWe = we; reqAddr = addr; reqSize = size; reqUns = uns; reqWdata = wdata;
    @(posedge clk); #1;
    reqValid = 1'b0; reqWe = ~we; reqAddr = $urandom; reqSize = 2'($urandom); reqWdata = $urandom;
    cyc = 1;
    while (rValid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    nCmp++;
    if (rValid !== 1'b1) begin
      nBad++;
      $display("FAIL %s timeout: resp_valid %b after %0d cycles, want 1", e.name, rValid, cyc);
    end
    nCmp++;
    if (cyc != e.lat) begin
      nBad++;
      $display("FAIL %s latency: got %0d want %0d", e.name, cyc, e.lat);
    end
    nCmp++;
    if (rRdata !== e.rdata || rErr !== e.err) begin
      nBad++;
      $display("FAIL %s data: got rdata=%h err=%b want rdata=%h err=%b", e.name, rRdata, rErr, e.rdata, e.err);
    end
    nCmp++;
    if (rReady !== 1'b0) begin
      nBad++;
      $display("FAIL %s ready_in_resp: got %b want 0", e.name, rReady);
    end
    repeat (hold) begin
      @(posedge clk); #1;
      nCmp++;
      if (rValid !== 1'b1 || rRdata !== e.rdata || rErr !== e.err || rReady !== 1'b0) begin
        nBad++;
        $display("FAIL %s hold: got v=%b rdata=%h err=%b rdy=%b want v=1 rdata=%h err=%b rdy=0",
                 e.name, rValid, rRdata, rErr, rReady, e.rdata, e.err);
      end
    end
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
    nCmp++;
    if (rValid !== 1'b0 || rReady !== 1'b1) begin
      nBad++;
      $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", e.name, rValid, rReady);
    end
  endtask

  function automatic logic mdlErr(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] mdlLoad(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = mdl[a[7:0]];
    h = {mdl[a[7:0] + 8'd1], mdl[a[7:0]]};
    if (s == 2'b00) return u ? {24'h0, b} : {{24{b[7]}}, b};
    if (s == 2'b01) return u ? {16'h0, h} : {{16{h[15]}}, h};
    return {mdl[a[7:0] + 8'd3], mdl[a[7:0] + 8'd2], h};
  endfunction

  task automatic test_reset();
    sel = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqSize = '0; reqUns = 1'b0;
    reqWdata = '0; respReady = 1'b0; rst0 = 1'b0; rst3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b1; rst3 = 1'b1;
    @(posedge clk); #1;
    nCmp++;
    if (ready0 !== 1'b1 || rv0 !== 1'b0 || rdata0 !== 32'h0 || err0 !== 1'b0) begin
      nBad++;
      $display("FAIL reset0: got rdy=%b v=%b rdata=%h err=%b want 1 0 0 0", ready0, rv0, rdata0, err0);
    end
    nCmp++;
    if (ready3 !== 1'b1 || rv3 !== 1'b0 || rdata3 !== 32'h0 || err3 !== 1'b0) begin
      nBad++;
      $display("FAIL reset3: got rdy=%b v=%b rdata=%h err=%b want 1 0 0 0", ready3, rv3, rdata3, err3);
    end
  endtask

  task automatic test_word();
    sel = 1'b0;
    issue("sw0", 1'b1, 32'h0, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b0, 0);
    issue("lw0", 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0, 0);
  endtask

  task automatic test_byte();
    issue("sw4", 1'b1, 32'h4, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0, 0);
    issue("sb5", 1'b1, 32'h5, 2'b00, 1'b0, 32'h5A5A5AAB, 32'h0, 1'b0, 1);
    issue("lw4", 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 32'h1122AB44, 1'b0, 0);
    issue("lb5", 1'b0, 32'h5, 2'b00, 1'b0, 32'h0, 32'hFFFFFFAB, 1'b0, 0);
    issue("lbu5", 1'b0, 32'h5, 2'b00, 1'b1, 32'h0, 32'h000000AB, 1'b0, 0);
    issue("lw4u", 1'b0, 32'h4, 2'b10, 1'b1, 32'h0, 32'h1122AB44, 1'b0, 0);
  endtask

  task automatic test_half();
    issue("sh2", 1'b1, 32'h2, 2'b01, 1'b0, 32'hFFFF8001, 32'h0, 1'b0, 0);
    issue("lh2", 1'b0, 32'h2, 2'b01, 1'b0, 32'h0, 32'hFFFF8001, 1'b0, 0);
    issue("lhu2", 1'b0, 32'h2, 2'b01, 1'b1, 32'h0, 32'h00008001, 1'b0, 0);
    issue("lh6", 1'b0, 32'h6, 2'b01, 1'b0, 32'h0, 32'h00001122, 1'b0, 0);
    issue("lw0_after_sh", 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 32'h80015678, 1'b0, 0);
  endtask

  task automatic test_errors();
    issue("err_lw2", 1'b0, 32'h2, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    issue("err_sh3", 1'b1, 32'h3, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    issue("err_size3", 1'b1, 32'h0, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    issue("err_lw_range", 1'b0, 32'd4096, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 2);
    issue("err_sw_range", 1'b1, 32'd4096, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    issue("lw0_after_err", 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 32'h80015678, 1'b0, 0);
    issue("lw4_after_err", 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 32'h1122AB44, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d, expD;
    logic [1:0]  s;
    logic        we, u, er;
    sel = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = 32'd64 + 32'(4 * i);
      d = $urandom;
      issue("fill", 1'b1, a, 2'b10, 1'b0, d, 32'h0, 1'b0, 0);
      {mdl[a[7:0] + 8'd3], mdl[a[7:0] + 8'd2], mdl[a[7:0] + 8'd1], mdl[a[7:0]]} = d;
    end
    for (int i = 0; i < 40; i++) begin
      a  = 32'd64 + 32'($urandom_range(0, 63));
      s  = 2'($urandom_range(0, 3));
      we = 1'($urandom);
      u  = 1'($urandom);
      d  = $urandom;
      er = mdlErr(a, s);
      expD = (er || we) ? 32'h0 : mdlLoad(a, s, u);
      issue("rand", we, a, s, u, d, expD, er, int'($urandom_range(0, 2)));
      if (!er && we) begin
        mdl[a[7:0]] = d[7:0];
        if (s != 2'b00) mdl[a[7:0] + 8'd1] = d[15:8];
        if (s == 2'b10) {mdl[a[7:0] + 8'd3], mdl[a[7:0] + 8'd2]} = d[31:16];
      end
    end
  endtask

  task automatic test_wait_backpressure();
    sel = 1'b1;
    issue("w3_sw", 1'b1, 32'h10, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    issue("w3_lw_hold", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 5);
    issue("w3_err", 1'b0, 32'h11, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, 1);
  endtask

  task automatic test_reset_mid_op();
    sel = 1'b1;
    issue("w3_sw8", 1'b1, 32'h8, 2'b10, 1'b0, 32'h01020304, 32'h0, 1'b0, 0);
    reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'h8; reqSize = 2'b10; reqWdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    #1;
    nCmp++;
    if (ready3 !== 1'b1 || rv3 !== 1'b0 || rdata3 !== 32'h0 || err3 !== 1'b0) begin
      nBad++;
      $display("FAIL mid_reset: got rdy=%b v=%b rdata=%h err=%b want 1 0 0 0", ready3, rv3, rdata3, err3);
    end
    @(negedge clk);
    rst3 = 1'b1;
    @(posedge clk); #1;
    issue("w3_lw8_after_rst", 1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 32'h01020304, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_wait_backpressure();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
